// File: rtl/nes_mem_arbiter_if.sv
// Bus bundle for nes_mem_arbiter: NES pool port, debugger port and Memory port.
// slave = arbiter view, master = the surrounding NES core / debugger / Memory.
interface nes_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  i_nes_en;
  logic                  i_nes_rw;
  logic [ADDR_WIDTH-1:0] i_nes_address;
  logic [DATA_WIDTH-1:0] i_nes_data;
  logic [DATA_WIDTH-1:0] o_nes_data;
  logic                  o_nes_wait;

  logic                  i_dbg_req;
  logic                  i_dbg_rw;
  logic [ADDR_WIDTH-1:0] i_dbg_address;
  logic [DATA_WIDTH-1:0] i_dbg_data;
  logic                  o_dbg_ack;
  logic [DATA_WIDTH-1:0] o_dbg_data;
  logic                  o_dbg_busy;

  logic                  o_mem_en;
  logic                  o_mem_wea;
  logic [ADDR_WIDTH-1:0] o_mem_address;
  logic [DATA_WIDTH-1:0] o_mem_data;
  logic [DATA_WIDTH-1:0] i_mem_data;

  modport slave (
    input  i_nes_en, i_nes_rw, i_nes_address, i_nes_data,
    output o_nes_data, o_nes_wait,
    input  i_dbg_req, i_dbg_rw, i_dbg_address, i_dbg_data,
    output o_dbg_ack, o_dbg_data, o_dbg_busy,
    output o_mem_en, o_mem_wea, o_mem_address, o_mem_data,
    input  i_mem_data
  );

  modport master (
    output i_nes_en, i_nes_rw, i_nes_address, i_nes_data,
    input  o_nes_data, o_nes_wait,
    output i_dbg_req, i_dbg_rw, i_dbg_address, i_dbg_data,
    input  o_dbg_ack, o_dbg_data, o_dbg_busy,
    input  o_mem_en, o_mem_wea, o_mem_address, o_mem_data,
    output i_mem_data
  );
endinterface

// File: rtl/nes_mem_arbiter.sv
// Shares one single-port synchronous Memory between the NES core (fixed priority) and a debugger
// (req/ack, serviced in idle NES cycles). Optional starvation guard: NES_MEM_ARB_STARVE_GUARD_EN.
module nes_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WAIT   = 15
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  nes_mem_arbiter_if.slave        bus
);

  if (MAX_WAIT < 1) begin : g_max_wait_check
    $error("nes_mem_arbiter: MAX_WAIT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    DATA    = 2'd2,
    ACK     = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  req_rw_q, req_rw_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
  logic [DATA_WIDTH-1:0] dbg_data_q, dbg_data_d;
  logic                  dbg_grant;
  logic                  starve;

`ifdef NES_MEM_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;

  assign starve = (wait_q == WAIT_W'(MAX_WAIT));
`else
  assign starve = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    req_rw_d   = req_rw_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    dbg_data_d = dbg_data_q;
    dbg_grant  = 1'b0;
`ifdef NES_MEM_ARB_STARVE_GUARD_EN
    wait_d     = wait_q;
`endif
    unique case (state_q)
      IDLE, ACK: begin
        // ACK accepts a new request exactly like IDLE, so back-to-back accesses have no dead cycle.
        if (bus.i_dbg_req) begin
          req_rw_d   = bus.i_dbg_rw;
          req_addr_d = bus.i_dbg_address;
          req_data_d = bus.i_dbg_data;
`ifdef NES_MEM_ARB_STARVE_GUARD_EN
          wait_d     = '0;
`endif
          state_d    = PENDING;
        end else begin
          state_d    = IDLE;
        end
      end
      PENDING: begin
        if (!bus.i_nes_en || starve) begin
          dbg_grant = 1'b1;
          state_d   = DATA;
        end else begin
`ifdef NES_MEM_ARB_STARVE_GUARD_EN
          wait_d = (wait_q == WAIT_W'(MAX_WAIT)) ? wait_q : wait_q + 1'b1;
`endif
        end
      end
      DATA: begin
        if (req_rw_q) begin
          dbg_data_d = bus.i_mem_data;
        end
        state_d = ACK;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      req_rw_q   <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      req_rw_q   <= req_rw_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      dbg_data_q <= dbg_data_d;
    end
  end

`ifdef NES_MEM_ARB_STARVE_GUARD_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  always_comb begin
    if (dbg_grant) begin
      bus.o_mem_en      = 1'b1;
      bus.o_mem_wea     = ~req_rw_q;
      bus.o_mem_address = req_addr_q;
      bus.o_mem_data    = req_data_q;
    end else begin
      bus.o_mem_en      = bus.i_nes_en;
      bus.o_mem_wea     = bus.i_nes_en & ~bus.i_nes_rw;
      bus.o_mem_address = bus.i_nes_address;
      bus.o_mem_data    = bus.i_nes_data;
    end
  end

  // Read data goes straight back to the NES; after a debugger issue it carries debugger data,
  // which the NES ignores because it made no access in that cycle.
  assign bus.o_nes_data = bus.i_mem_data;
  assign bus.o_nes_wait = (state_q == PENDING) && starve && bus.i_nes_en;
  assign bus.o_dbg_ack  = (state_q == ACK);
  assign bus.o_dbg_busy = (state_q == PENDING) || (state_q == DATA);
  assign bus.o_dbg_data = dbg_data_q;

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Self-checking bench for nes_mem_arbiter: per-cycle vector table plus hand sequences for
// reset-in-DATA and the starvation case (expectations follow NES_MEM_ARB_STARVE_GUARD_EN).
module tb_nes_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  nes_mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  nes_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MAX_WAIT(15)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Behavioural single-port synchronous Memory, read-first, 1-cycle latency.
  logic [7:0] mem [0:65535];
  logic [7:0] mem_rdata = 8'h00;
  assign bus.i_mem_data = mem_rdata;
  always @(posedge clk) begin
    if (bus.o_mem_en) begin
      if (bus.o_mem_wea) mem[bus.o_mem_address] <= bus.o_mem_data;
      mem_rdata <= mem[bus.o_mem_address];
    end
  end

  typedef struct {
    logic        nes_en;
    logic        nes_rw;
    logic [15:0] nes_addr;
    logic [7:0]  nes_data;
    logic        dbg_req;
    logic        dbg_rw;
    logic [15:0] dbg_addr;
    logic [7:0]  dbg_data;
  } stim_t;

  typedef struct {
    logic        mem_en;
    logic        mem_wea;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        busy;
    logic        ack;
    logic [7:0]  dbg_data;
    logic        chk_nd;
    logic [7:0]  nes_data;
  } expect_t;

  typedef struct {
    stim_t   s;
    expect_t e;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    bus.i_nes_en      = s.nes_en;
    bus.i_nes_rw      = s.nes_rw;
    bus.i_nes_address = s.nes_addr;
    bus.i_nes_data    = s.nes_data;
    bus.i_dbg_req     = s.dbg_req;
    bus.i_dbg_rw      = s.dbg_rw;
    bus.i_dbg_address = s.dbg_addr;
    bus.i_dbg_data    = s.dbg_data;
  endtask

  task automatic drive_idle();
    drive('{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00});
  endtask

  initial begin
    mem[16'h0010] = 8'h3C;
    mem[16'h0020] = 8'h77;
    mem[16'h0123] = 8'h00;
    mem[16'h0FFF] = 8'hEE;
    drive_idle();

    // Stimulus {nes en,rw,addr,data, dbg req,rw,addr,data}; expect {mem en,wea,addr,data, busy,ack,dbg_data, chk,nes_data}
    // Idle NES: write A5 to 0x0123, then read it back
    vq.push_back('{'{0,0,16'h0000,8'h00, 1,0,16'h0123,8'hA5}, '{0,0,16'h0000,8'h00, 0,0,8'h00, 0,8'h00}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 0,1,16'h0FFF,8'hFF}, '{1,1,16'h0123,8'hA5, 1,0,8'h00, 0,8'h00}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00}, '{0,0,16'h0000,8'h00, 1,0,8'h00, 0,8'h00}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00}, '{0,0,16'h0000,8'h00, 0,1,8'h00, 0,8'h00}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 1,1,16'h0123,8'h5A}, '{0,0,16'h0000,8'h00, 0,0,8'h00, 0,8'h00}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00}, '{1,0,16'h0123,8'h5A, 1,0,8'h00, 0,8'h00}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00}, '{0,0,16'h0000,8'h00, 1,0,8'h00, 1,8'hA5}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00}, '{0,0,16'h0000,8'h00, 0,1,8'hA5, 0,8'h00}});
    // NES reads 0x0010 for 5 cycles while the debugger reads 0x0020
    vq.push_back('{'{1,1,16'h0010,8'h00, 1,1,16'h0020,8'h00}, '{1,0,16'h0010,8'h00, 0,0,8'hA5, 0,8'h00}});
    for (int i = 0; i < 4; i++)
      vq.push_back('{'{1,1,16'h0010,8'h00, 0,0,16'h0000,8'h00}, '{1,0,16'h0010,8'h00, 1,0,8'hA5, 1,8'h3C}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00}, '{1,0,16'h0020,8'h00, 1,0,8'hA5, 1,8'h3C}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00}, '{0,0,16'h0000,8'h00, 1,0,8'hA5, 1,8'h77}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00}, '{0,0,16'h0000,8'h00, 0,1,8'h77, 0,8'h00}});
    // Requests to 0x0FFF while busy are ignored
    vq.push_back('{'{0,0,16'h0000,8'h00, 1,1,16'h0123,8'h00}, '{0,0,16'h0000,8'h00, 0,0,8'h77, 0,8'h00}});
    vq.push_back('{'{1,1,16'h0010,8'h00, 1,1,16'h0FFF,8'h00}, '{1,0,16'h0010,8'h00, 1,0,8'h77, 0,8'h00}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 1,1,16'h0FFF,8'h00}, '{1,0,16'h0123,8'h00, 1,0,8'h77, 1,8'h3C}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 1,1,16'h0FFF,8'h00}, '{0,0,16'h0000,8'h00, 1,0,8'h77, 1,8'hA5}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00}, '{0,0,16'h0000,8'h00, 0,1,8'hA5, 0,8'h00}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00}, '{0,0,16'h0000,8'h00, 0,0,8'hA5, 0,8'h00}});
    // Back-to-back: write 0x11 to 0x0200, new read accepted in the ACK cycle; NES write during DATA
    vq.push_back('{'{0,0,16'h0000,8'h00, 1,0,16'h0200,8'h11}, '{0,0,16'h0000,8'h00, 0,0,8'hA5, 0,8'h00}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00}, '{1,1,16'h0200,8'h11, 1,0,8'hA5, 0,8'h00}});
    vq.push_back('{'{1,0,16'h0300,8'h42, 0,0,16'h0000,8'h00}, '{1,1,16'h0300,8'h42, 1,0,8'hA5, 0,8'h00}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 1,1,16'h0200,8'h00}, '{0,0,16'h0000,8'h00, 0,1,8'hA5, 0,8'h00}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00}, '{1,0,16'h0200,8'h00, 1,0,8'hA5, 0,8'h00}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00}, '{0,0,16'h0000,8'h00, 1,0,8'hA5, 1,8'h11}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00}, '{0,0,16'h0000,8'h00, 0,1,8'h11, 0,8'h00}});
    vq.push_back('{'{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00}, '{0,0,16'h0000,8'h00, 0,0,8'h11, 0,8'h00}});

    // Reset state
    #1;
    check("rst ack",      32'(bus.o_dbg_ack),  32'h0);
    check("rst busy",     32'(bus.o_dbg_busy), 32'h0);
    check("rst dbg_data", 32'(bus.o_dbg_data), 32'h0);
    check("rst nes_wait", 32'(bus.o_nes_wait), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].s);
      #1;
      check($sformatf("v%0d mem_en", i),   32'(bus.o_mem_en),      32'(vq[i].e.mem_en));
      check($sformatf("v%0d mem_wea", i),  32'(bus.o_mem_wea),     32'(vq[i].e.mem_wea));
      check($sformatf("v%0d mem_addr", i), 32'(bus.o_mem_address), 32'(vq[i].e.mem_addr));
      check($sformatf("v%0d mem_data", i), 32'(bus.o_mem_data),    32'(vq[i].e.mem_data));
      check($sformatf("v%0d busy", i),     32'(bus.o_dbg_busy),    32'(vq[i].e.busy));
      check($sformatf("v%0d ack", i),      32'(bus.o_dbg_ack),     32'(vq[i].e.ack));
      check($sformatf("v%0d dbg_data", i), 32'(bus.o_dbg_data),    32'(vq[i].e.dbg_data));
      check($sformatf("v%0d nes_wait", i), 32'(bus.o_nes_wait),    32'h0);
      if (vq[i].e.chk_nd)
        check($sformatf("v%0d nes_data", i), 32'(bus.o_nes_data), 32'(vq[i].e.nes_data));
    end
    check("mem 0x0300 written by NES", 32'(mem[16'h0300]), 32'h42);

    // Reset asserted while in DATA: access dropped, outputs cleared at once, no ack afterwards
    @(negedge clk);
    drive('{0,0,16'h0000,8'h00, 1,1,16'h0020,8'h00});
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    #1;
    check("pre-reset busy in DATA", 32'(bus.o_dbg_busy), 32'h1);
    rst = 1'b1;
    #1;
    check("async rst busy",     32'(bus.o_dbg_busy), 32'h0);
    check("async rst ack",      32'(bus.o_dbg_ack),  32'h0);
    check("async rst dbg_data", 32'(bus.o_dbg_data), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("post-rst c%0d ack", k),  32'(bus.o_dbg_ack),  32'h0);
      check($sformatf("post-rst c%0d busy", k), 32'(bus.o_dbg_busy), 32'h0);
    end
    @(negedge clk);
    drive('{0,0,16'h0000,8'h00, 1,0,16'h0400,8'h99});
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      drive_idle();
      #1;
      check($sformatf("post-rst req T0+%0d ack", j), 32'(bus.o_dbg_ack), 32'(j == 3));
    end

    // NES enabled every cycle while the debugger reads 0x0020
    for (int k = 0; k <= 30; k++) begin
      logic       x_wait;
      logic       x_ack;
      logic       x_busy;
      logic [15:0] x_addr;
      @(negedge clk);
      drive('{1,1,16'h0010,8'h00, (k == 0),1,16'h0020,8'h00});
      #1;
`ifdef NES_MEM_ARB_STARVE_GUARD_EN
      x_wait = (k == 16);
      x_ack  = (k == 18);
      x_busy = (k >= 1) && (k <= 17);
      x_addr = (k == 16) ? 16'h0020 : 16'h0010;
      if (k == 18) begin
        check("starve held NES read data", 32'(bus.o_nes_data), 32'h3C);
        check("starve dbg_data",           32'(bus.o_dbg_data), 32'h77);
      end
`else
      x_wait = 1'b0;
      x_ack  = 1'b0;
      x_busy = (k >= 1);
      x_addr = 16'h0010;
`endif
      check($sformatf("starve k%0d nes_wait", k), 32'(bus.o_nes_wait),    32'(x_wait));
      check($sformatf("starve k%0d ack", k),      32'(bus.o_dbg_ack),     32'(x_ack));
      check($sformatf("starve k%0d busy", k),     32'(bus.o_dbg_busy),    32'(x_busy));
      check($sformatf("starve k%0d mem_addr", k), 32'(bus.o_mem_address), 32'(x_addr));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nes_mem_arbiter.md
Name: nes_mem_arbiter

Overview:
- Shares one single-port synchronous Memory instance (1-cycle read latency) between two requesters.
- Requester 1 is the NES core: fixed-priority, pass-through, no handshake.
- Requester 2 is the debugger: request/ack handshake, one outstanding access, serviced in idle NES cycles.
- Sits between the NES memory-pool ports, the debugger memory port and a Memory block, one instance per pool.

Parameters:
- ADDR_WIDTH, 16, address width of all three ports.
- DATA_WIDTH, 8, data width of all three ports.
- MAX_WAIT, 15, PENDING cycles before the starvation guard forces a debugger access (used only with the optional feature).

Ports:
- i_clk  in  1  single clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_nes_en  in  1  NES access this cycle.
- i_nes_rw  in  1  1=read, 0=write.
- i_nes_address  in  ADDR_WIDTH  NES address.
- i_nes_data  in  DATA_WIDTH  NES write data.
- o_nes_data  out  DATA_WIDTH  NES read data, valid the cycle after its read.
- o_nes_wait  out  1  NES access blocked this cycle; NES holds its request.
- i_dbg_req  in  1  debugger access request, sampled only when o_dbg_busy=0.
- i_dbg_rw  in  1  1=read, 0=write.
- i_dbg_address  in  ADDR_WIDTH  debugger address.
- i_dbg_data  in  DATA_WIDTH  debugger write data.
- o_dbg_ack  out  1  one-cycle pulse: access complete.
- o_dbg_data  out  DATA_WIDTH  registered read data, valid from the o_dbg_ack cycle until the next read completes.
- o_dbg_busy  out  1  request outstanding; new requests are ignored.
- o_mem_en  out  1  memory enable.
- o_mem_wea  out  1  memory write enable (1=write).
- o_mem_address  out  ADDR_WIDTH  memory address.
- o_mem_data  out  DATA_WIDTH  memory write data.
- i_mem_data  in  DATA_WIDTH  memory read data, one cycle after o_mem_en.

Behaviour:
- Reset values:
  - state=IDLE.
  - o_dbg_ack=0, o_dbg_data=0, o_dbg_busy=0, o_nes_wait=0.
  - Latched request registers and wait counter = 0.
- Reset is asynchronous and may assert at any point. A pending or in-flight debugger access is dropped and no ack is issued.
- Memory mux is combinational.
  - When the NES is granted: o_mem_en=i_nes_en, o_mem_wea=i_nes_en & ~i_nes_rw, o_mem_address/o_mem_data = NES inputs.
  - When the debugger is granted: the mux drives the latched debugger request instead.
- o_nes_data = i_mem_data, combinational. In the cycle after a debugger issue this carries debugger data; that is harmless because the NES did not access memory in the previous cycle.
- Debugger FSM states: IDLE, PENDING, DATA, ACK.
  - IDLE:
    - o_dbg_busy=0.
    - On i_dbg_req=1: latch rw/address/data, clear the wait counter, go to PENDING.
    - No memory access is issued in the request cycle, even if the NES is idle.
  - PENDING:
    - o_dbg_busy=1.
    - If i_nes_en=0: grant the debugger and drive memory with the latched request (the issue cycle), go to DATA.
    - Else: the NES keeps the memory, stay in PENDING, wait counter increments, saturating at MAX_WAIT.
  - DATA:
    - o_dbg_busy=1.
    - The NES has the memory.
    - If the latched request is a read, register i_mem_data into o_dbg_data. A write leaves o_dbg_data unchanged.
    - Go to ACK.
  - ACK:
    - o_dbg_ack=1 for exactly one cycle, o_dbg_busy=0.
    - An i_dbg_req this cycle is accepted as in IDLE (back-to-back allowed); otherwise go to IDLE.
- Latency: request at T0 with the NES idle gives issue at T0+1, data capture at T0+2 and ack at T0+3. Each NES-busy cycle in PENDING adds one cycle.
- The NES is never blocked without the optional feature: o_nes_wait=0 constantly.
- Debugger write semantics: memory updated at the issue-cycle edge; o_dbg_ack is still 2 cycles later.
- i_dbg_* inputs are don't-care after the latch cycle.
- Address and data are passed through unmodified; there is no address translation.

Optional Feature:
- Macro: NES_MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - In PENDING with wait counter == MAX_WAIT, the debugger is granted regardless of i_nes_en, and o_nes_wait = i_nes_en in that cycle.
  - The NES access is not performed; the NES must hold it and it is serviced next cycle.
  - The wait counter width is clog2(MAX_WAIT+1).
- Undefined: no wait counter is built, o_nes_wait is tied to 0, and the debugger may wait indefinitely.

Test Plan:
- Idle NES, debugger write 0xA5 to 0x0123, then read 0x0123 -> each ack arrives 3 cycles after its request; the read returns o_dbg_data=0xA5.
- NES reads 0x0010 continuously for 5 cycles while the debugger reads 0x0020 -> NES data is uninterrupted; debugger issue occurs in the first NES-idle cycle; ack arrives 2 cycles after issue.
- i_dbg_req pulsed again while o_dbg_busy=1 (address 0x0FFF) -> ignored; exactly one ack, for the original address.
- Back-to-back requests: new request asserted in the ACK cycle -> accepted; second ack 3 cycles later; no dead cycle in between.
- Reset asserted in DATA state -> o_dbg_ack never pulses, all outputs go to 0 immediately, state is IDLE after release.
- With NES_MEM_ARB_STARVE_GUARD_EN and MAX_WAIT=15, NES enabled every cycle -> debugger issues after 15 PENDING cycles; o_nes_wait=1 for exactly that cycle; the held NES access completes next cycle. Without the macro: no ack is issued, o_nes_wait stays 0.
